cast_signed_pipe: RTL and testbench

Pipelined, multi-lane signed fixed-point format converter for the NN datapath. It sits between the neuron MAC/accumulator outputs and the next layer's input or activation stage. Each lane converts any signed Q format to any other: widening or narrowing the integer part, widening or narrowing the fractional part. Narrowing is handled by selectable rounding and by saturation, with a per-lane overflow flag.

---
 rtl/cast_signed_pipe_if.sv | 30 +++
 rtl/cast_signed_pipe.sv | 158 +++++++++++++++
 tb/tb_cast_signed_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cast_signed_pipe_if.sv
// cast_signed_pipe_if: sample bus between a producer and the format converter.
// Parameters: DIN_WIDTH / DOUT_WIDTH per-lane word widths, PARALLEL lane count.
// Signals:
//   din        producer -> converter, packed lanes, lane 0 in the LSBs
//   din_valid  producer -> converter, qualifies din for all lanes
//   dout       converter -> consumer, packed converted lanes
//   dout_valid converter -> consumer, qualifies dout and ovf
//   ovf        converter -> consumer, per-lane saturation flag
// Modports: master (producer/consumer side), slave (converter side).
interface cast_signed_pipe_if #(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned PARALLEL   = 1
);
    logic [DIN_WIDTH*PARALLEL-1:0]  din;
    logic                           din_valid;
    logic [DOUT_WIDTH*PARALLEL-1:0] dout;
    logic                           dout_valid;
    logic [PARALLEL-1:0]            ovf;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, ovf
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, ovf
    );
endinterface

// File: rtl/cast_signed_pipe.sv
// cast_signed_pipe: 2-stage multi-lane signed fixed-point format converter.
// Stage 1 aligns the binary point (rounding on right shift, zero-fill on left
// shift); stage 2 saturates to DOUT_WIDTH and raises a per-lane ovf flag.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (valid pipeline, outputs, counter)
//   bus        cast_signed_pipe_if.slave: din/din_valid in, dout/dout_valid/ovf out
//   sat_clr    clears sat_count (counter build only)
//   sat_count  saturation event count (constant 0 unless counter build)
// Optional feature macro: CAST_SIGNED_PIPE_SAT_COUNT_EN builds the saturating
// event counter; without it sat_clr is ignored and sat_count reads 0.
module cast_signed_pipe #(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DIN_POINT  = 8,
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned DOUT_POINT = 4,
    parameter int unsigned PARALLEL   = 1,
    parameter int unsigned ROUND_MODE = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cast_signed_pipe_if.slave    bus,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] sat_count
);
    // Right shift amount (fraction narrowing) and left shift amount (widening).
    localparam int unsigned RSH = (DIN_POINT > DOUT_POINT) ? DIN_POINT - DOUT_POINT : 0;
    localparam int unsigned LSH = (DOUT_POINT > DIN_POINT) ? DOUT_POINT - DIN_POINT : 0;
    // Extended width for the rounding add: one guard bit keeps the carry.
    localparam int unsigned EW  = DIN_WIDTH + 1;
    // Width of the aligned intermediate held between the two stages.
    localparam int unsigned IW  = (RSH > 0) ? EW - RSH : DIN_WIDTH + LSH;

    logic                           v1_q;
    logic                           v2_q;
    logic [DOUT_WIDTH*PARALLEL-1:0] dout_vec;
    logic [PARALLEL-1:0]            ovf_vec;

    // Valid pipeline: the only state that must be cleared to drop in-flight samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= bus.din_valid;
            v2_q <= v1_q;
        end
    end

    for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
        logic signed [DIN_WIDTH-1:0]  x;
        logic signed [IW-1:0]         mid_d;
        logic signed [IW-1:0]         mid_q;
        logic        [DOUT_WIDTH-1:0] dout_d;
        logic        [DOUT_WIDTH-1:0] dout_q;
        logic                         ovf_d;
        logic                         ovf_q;

        assign x = bus.din[l*DIN_WIDTH +: DIN_WIDTH];

        if (RSH > 0) begin : g_rsh
            localparam logic [EW-1:0] HALF = EW'(1) << (RSH - 1);
            logic        [EW-1:0] bias;
            logic signed [EW-1:0] sum;

            // Rounding bias; half-even uses the kept LSB to break exact ties.
            always_comb begin
                bias = '0;
                if (ROUND_MODE == 1) begin
                    bias = HALF;
                end else if (ROUND_MODE == 2) begin
                    bias = HALF - EW'(1) + EW'(x[RSH]);
                end
            end

            assign sum   = EW'(x) + bias;
            assign mid_d = IW'(sum >>> RSH);
        end else begin : g_lsh
            assign mid_d = IW'(x) <<< LSH;
        end

        // Data stage registers run freely; validity is tracked separately.
        always_ff @(posedge clk) begin
            mid_q <= mid_d;
        end

        if (IW > DOUT_WIDTH) begin : g_sat
            localparam logic signed [IW-1:0] MAXV =
                {{(IW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
            localparam logic signed [IW-1:0] MINV =
                {{(IW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

            // Clamp to the output range and flag the lane.
            always_comb begin
                dout_d = mid_q[DOUT_WIDTH-1:0];
                ovf_d  = 1'b0;
                if (mid_q > MAXV) begin
                    dout_d = MAXV[DOUT_WIDTH-1:0];
                    ovf_d  = 1'b1;
                end else if (mid_q < MINV) begin
                    dout_d = MINV[DOUT_WIDTH-1:0];
                    ovf_d  = 1'b1;
                end
            end
        end else begin : g_fit
            // Intermediate always fits: plain sign extension, never overflows.
            assign dout_d = DOUT_WIDTH'(mid_q);
            assign ovf_d  = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                dout_q <= dout_d;
                ovf_q  <= ovf_d;
            end
        end

        assign dout_vec[l*DOUT_WIDTH +: DOUT_WIDTH] = dout_q;
        assign ovf_vec[l]                           = ovf_q;
    end

    assign bus.dout       = dout_vec;
    assign bus.ovf        = ovf_vec;
    assign bus.dout_valid = v2_q;

`ifdef CAST_SIGNED_PIPE_SAT_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating event counter; clear has priority over a coincident event.
    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (v2_q && (|ovf_vec) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_count      = '0;
`endif
endmodule

// File: tb/tb_cast_signed_pipe.sv
// Scoreboard bench: five converter configurations share one 4-lane stimulus
// stream; each has its own expected-response queue and monitor.
module tb_cast_signed_pipe;
    localparam int NCFG  = 5;
    localparam int LANES = 4;
    localparam int CW    = 3;
    // Per-configuration parameters: input point, output width/point, rounding.
    localparam int CFG_DP[NCFG]   = '{8, 8, 8, 8, 4};
    localparam int CFG_OW[NCFG]   = '{8, 8, 8, 24, 8};
    localparam int CFG_OP[NCFG]   = '{4, 4, 4, 12, 6};
    localparam int CFG_MODE[NCFG] = '{0, 1, 2, 1, 2};

    typedef struct {
        logic [LANES-1:0][23:0] y;
        logic [LANES-1:0]       o;
        int                     due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [16*LANES-1:0] din = '0;
    logic                din_valid = 1'b0;
    logic                sat_clr = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   init_chk = 1'b0;
    bit   done = 1'b0;
    exp_t sbq[NCFG][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact rational value scaled, floor-divided, rounded, clamped.
    function automatic void model(input logic [15:0] x, input int dp, input int ow,
                                  input int op, input int mode,
                                  output logic [23:0] y, output logic o);
        longint v, q, r, d, mx, mn;
        int s;
        v = longint'($signed(x));
        s = dp - op;
        if (s > 0) begin
            d = longint'(1) << s;
            q = v / d;
            r = v - q * d;
            if (r < 0) begin
                q = q - 1;
                r = r + d;
            end
            if (mode == 1 && 2 * r >= d) q = q + 1;
            if (mode == 2 && (2 * r > d || (2 * r == d && (q % 2) != 0))) q = q + 1;
        end else begin
            q = v * (longint'(1) << (-s));
        end
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        o  = 1'b0;
        if (q > mx) begin
            q = mx;
            o = 1'b1;
        end else if (q < mn) begin
            q = mn;
            o = 1'b1;
        end
        y = 24'(q);
    endfunction

    // One stimulus cycle; expectations are queued for every configuration.
    task automatic drive(input logic [16*LANES-1:0] d, input bit v, input bit clr);
        exp_t e;
        logic [15:0] lane;
        @(posedge clk);
        #1;
        din       = d;
        din_valid = v;
        sat_clr   = clr;
        if (v && !rst) begin
            for (int c = 0; c < NCFG; c++) begin
                for (int l = 0; l < LANES; l++) begin
                    lane = d[l*16 +: 16];
                    model(lane, CFG_DP[c], CFG_OW[c], CFG_OP[c], CFG_MODE[c], e.y[l], e.o[l]);
                end
                e.due = cyc + 2;
                sbq[c].push_back(e);
            end
        end
    endtask

    // Reset discards anything not already on the output.
    task automatic set_rst(input bit r);
        @(posedge clk);
        #1;
        rst       = r;
        din_valid = 1'b0;
        if (r) begin
            for (int c = 0; c < NCFG; c++) begin
                while (sbq[c].size() > 0 && sbq[c][$].due > cyc) void'(sbq[c].pop_back());
            end
        end
    endtask

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int OW = CFG_OW[c];
        cast_signed_pipe_if #(.DIN_WIDTH(16), .DOUT_WIDTH(OW), .PARALLEL(LANES)) bus ();
        logic [CW-1:0] sat_count;
        int            exp_cnt = 0;
        bit            done_chk = 1'b0;

        assign bus.din       = din;
        assign bus.din_valid = din_valid;

        cast_signed_pipe #(
            .DIN_WIDTH (16),
            .DIN_POINT (CFG_DP[c]),
            .DOUT_WIDTH(OW),
            .DOUT_POINT(CFG_OP[c]),
            .PARALLEL  (LANES),
            .ROUND_MODE(CFG_MODE[c]),
            .CNT_WIDTH (CW)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .sat_clr  (sat_clr),
            .sat_count(sat_count)
        );

        always @(negedge clk) begin
            exp_t e;
            bit   exp_v;
            bit   ev;
            if (mon_en) begin
                n_cmp++;
                if (sat_count !== CW'(exp_cnt)) begin
                    n_bad++;
                    $display("FAIL cfg%0d sat_count cyc %0d: got %0d want %0d", c, cyc, sat_count, exp_cnt);
                end
                if (init_chk) begin
                    n_cmp++;
                    if (bus.dout !== '0 || bus.ovf !== '0) begin
                        n_bad++;
                        $display("FAIL cfg%0d reset_outputs: got dout %h ovf %b want 0", c, bus.dout, bus.ovf);
                    end
                end
                exp_v = (sbq[c].size() > 0) && (sbq[c][0].due == cyc);
                ev    = 1'b0;
                n_cmp++;
                if (bus.dout_valid !== exp_v) begin
                    n_bad++;
                    $display("FAIL cfg%0d dout_valid cyc %0d: got %b want %b", c, cyc, bus.dout_valid, exp_v);
                end
                if (exp_v) begin
                    e  = sbq[c].pop_front();
                    ev = |e.o;
                    for (int l = 0; l < LANES; l++) begin
                        n_cmp++;
                        if (bus.dout[l*OW +: OW] !== e.y[l][OW-1:0] || bus.ovf[l] !== e.o[l]) begin
                            n_bad++;
                            $display("FAIL cfg%0d lane%0d data cyc %0d: got %h/%b want %h/%b", c, l, cyc,
                                     bus.dout[l*OW +: OW], bus.ovf[l], e.y[l][OW-1:0], e.o[l]);
                        end
                    end
                end
`ifdef CAST_SIGNED_PIPE_SAT_COUNT_EN
                if (rst || sat_clr) exp_cnt = 0;
                else if (ev && exp_cnt < (1 << CW) - 1) exp_cnt++;
`else
                ev = ev;
`endif
                if (done && !done_chk) begin
                    done_chk = 1'b1;
                    n_cmp++;
                    if (sbq[c].size() != 0) begin
                        n_bad++;
                        $display("FAIL cfg%0d leftover: got %0d pending want 0", c, sbq[c].size());
                    end
                end
            end
        end
    end

    logic [15:0] bnd[12] = '{16'h0180, 16'h7FFF, 16'h8000, 16'h0018, 16'h0028, 16'hFFE8,
                             16'h7FF8, 16'hFF80, 16'h0000, 16'hFFFF, 16'h0008, 16'h07F8};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 2) == 0) return bnd[$urandom_range(0, 11)];
        return 16'($urandom);
    endfunction

    function automatic logic [16*LANES-1:0] rand_word();
        logic [16*LANES-1:0] w;
        for (int l = 0; l < LANES; l++) w[l*16 +: 16] = pick();
        return w;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mon_en   = 1'b1;
        init_chk = 1'b1;
        set_rst(1'b0);
        init_chk = 1'b0;

        // Directed vectors from the conversion rules, mixed across lanes.
        drive({16'h0018, 16'h8000, 16'h7FFF, 16'h0180}, 1'b1, 1'b0);
        drive({16'h7FF8, 16'hFFE8, 16'h0028, 16'h0018}, 1'b1, 1'b0);
        drive({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b0);
        drive({16'hFF80, 16'h0180, 16'hFF80, 16'h7FFF}, 1'b1, 1'b0);
        drive({16'h0008, 16'hFFF8, 16'h0038, 16'hFFC8}, 1'b1, 1'b1);
        drive({16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}, 1'b1, 1'b0);
        drive({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b0);
        drive({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 1'b0);

        // Random burst with gaps and occasional counter clears.
        for (int i = 0; i < 300; i++) begin
            drive(rand_word(), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of a dense burst.
        for (int i = 0; i < 5; i++) drive(rand_word(), 1'b1, 1'b0);
        set_rst(1'b1);
        drive(rand_word(), 1'b1, 1'b0);
        set_rst(1'b0);
        for (int i = 0; i < 200; i++) begin
            drive(rand_word(), $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
        end

        for (int i = 0; i < 5; i++) drive('0, 1'b0, 1'b0);
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
